systolic_mac_array: RTL
=======================

# systolic_mac_array

Output-stationary ARRAY_SIZE×ARRAY_SIZE signed multiply-accumulate array. It sits directly downstream of the operand queue stage: each accepted beat carries one data element per row and one weight element per column. Operands are skewed internally and accumulated in the PEs. After a programmed number of beats, the block drains the C = A·B tile one element at a time over a valid/ready result port.

## Interface
- ARRAY_SIZE, default 2: rows = columns = N.
- DATA_W, default 16: signed operand width.
- ACC_W, default 40: signed accumulator/result width; ACC_W ≥ 2*DATA_W.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a tile; ignored unless state is IDLE.
- k_len  in  10  beats per tile (inner dimension K); sampled on accepted start.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- data_in  in  N*DATA_W  slice i = A[i][k] for row i.
- weight_in  in  N*DATA_W  slice j = B[k][j] for column j.
- out_valid  out  1  result element presented.
- out_ready  in  1  consumer accepts result.
- out_data  out  ACC_W  C[row][col], signed.
- out_row  out  $clog2(N) (min 1)  row index of out_data.
- out_col  out  $clog2(N) (min 1)  column index of out_data.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse after the last result handshake.

## Operation
- The FSM has four states: IDLE, COMPUTE, FLUSH and DRAIN.
- **IDLE**
  - On start: latch k_len into beat_cnt_max, clear all accumulators and valid tokens, clear beat_cnt.
  - Go to COMPUTE, or directly to DRAIN if k_len = 0 (drains zeros).
- **COMPUTE**
  - in_ready = 1.
  - A beat is accepted when in_valid & in_ready; each acceptance increments beat_cnt.
  - When the K-th beat is accepted, go to FLUSH and load flush_cnt = 2N-2.
- **FLUSH**
  - in_ready = 0.
  - flush_cnt decrements each cycle; at 0 (2N-1 cycles total), go to DRAIN with drain index = 0.
- **DRAIN**
  - Present C in row-major order: index r*N+c.
  - Advance on out_valid & out_ready.
  - After the handshake of index N*N-1: pulse done, go to IDLE.
- **Datapath**
  - The row-i data input passes through i skew registers; the column-j weight input passes through j skew registers.
  - A valid token is injected with each accepted beat; token = 0 when no beat is accepted (bubble).
  - PE(i,j) registers data to the right and weight down, each together with its token.
  - PE(i,j) accumulates acc += data*weight when its data token = 1.
  - Data and weight arrive at PE(i,j) aligned, i+j cycles after injection.
- **Arithmetic**
  - Signed DATA_W×DATA_W product, 2*DATA_W bits, sign-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W; no saturation or overflow flag.
- Skew and PE registers shift only when tokens are present or on bubbles; they are never stalled. in_valid = 0 simply inserts a bubble.
- start while busy is ignored with no side effects.

## Timing
- Reset values:
  - state = IDLE; in_ready = 0, out_valid = 0, busy = 0, done = 0.
  - out_data = 0, out_row = 0, out_col = 0.
  - All accumulators, skew/PE registers and tokens = 0.
- in_ready is a decode of the registered state only; there is no combinational path from in_valid.
- out_valid, out_data, out_row and out_col are registered.
- out_valid is high from the first DRAIN cycle until the final handshake.
- While out_valid & !out_ready, out_data, out_row and out_col hold stable.
- Latency: a beat accepted at edge t updates acc(i,j) at edge t+1+i+j.
- Last beat accepted at edge T: the final accumulation lands at edge T+2N-1, which is the last FLUSH edge. out_valid rises at edge T+2N-1.
- With start at edge 0 and in_valid held high, out_valid first rises at edge K+2N-1 (N=2, K=2 → edge 5).
- Full drain with out_ready held high takes N*N cycles. done is asserted in the cycle after the last handshake edge; busy falls in the same cycle.
- rst_n asserted mid-tile: immediate return to reset values; partial results are discarded.
- Back-to-back tiles: start is accepted in the first IDLE cycle after done.

## Test plan
- **Basic product.** N=2, K=2. Inputs: beat0 data{3,1} weight{6,5}; beat1 data{4,2} weight{8,7}; in_valid and out_ready continuous.
  - Required: outputs (0,0)=19, (0,1)=22, (1,0)=43, (1,1)=50 in that order.
  - Required: first out_valid 5 cycles after start; done one cycle after the 4th handshake.
- **Signed operands.** K=1, A00 = 0xFFFD (-3), B00 = 7, all other operands 0.
  - Required: C00 = -21, i.e. ACC_W-bit 0xFF_FFFF_FFEB; other elements 0.
- **Bubbles and backpressure.** Basic-product stimulus with in_valid low on alternate cycles, and out_ready low for 3 cycles at the (0,1) element.
  - Required: same four results.
  - Required: out_data = 22 and out_col = 1 held stable throughout the stall.
- **k_len = 0.** start goes directly to DRAIN.
  - Required: four zero results; done pulse; in_ready never asserted.
- **Reset and start misuse.**
  - rst_n pulsed low during FLUSH: all outputs return to reset values; a subsequent basic-product tile produces 19/22/43/50.
  - start during COMPUTE is ignored; the beat count is unchanged.

Source files
------------

// File: rtl/systolic_mac_array.sv
// ---------------------------------------------------------------------------
// systolic_mac_array
//   Output-stationary ARRAY_SIZE x ARRAY_SIZE signed multiply-accumulate
//   array. Each accepted operand beat carries one A element per row and one
//   B element per column; after k_len beats and a pipeline flush the C tile
//   is drained one element per handshake in row-major order.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : one-cycle pulse, begins a tile (only honoured in IDLE)
//   k_len       : beats per tile, sampled on an accepted start
//   in_valid    : operand beat present
//   in_ready    : beat accepted this cycle (COMPUTE state decode)
//   data_in     : slice i = A[i][k]
//   weight_in   : slice j = B[k][j]
//   out_valid   : result element presented
//   out_ready   : consumer accepts result
//   out_data    : C[out_row][out_col], signed ACC_W
//   out_row/col : index of out_data
//   busy        : state != IDLE
//   done        : one-cycle pulse after the last result handshake
// ---------------------------------------------------------------------------
module systolic_mac_array #(
    parameter int ARRAY_SIZE = 2,
    parameter int DATA_W     = 16,
    parameter int ACC_W      = 40
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic                                               start,
    input  logic [9:0]                                         k_len,
    input  logic                                               in_valid,
    output logic                                               in_ready,
    input  logic [ARRAY_SIZE*DATA_W-1:0]                       data_in,
    input  logic [ARRAY_SIZE*DATA_W-1:0]                       weight_in,
    output logic                                               out_valid,
    input  logic                                               out_ready,
    output logic signed [ACC_W-1:0]                            out_data,
    output logic [((ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1)-1:0] out_row,
    output logic [((ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1)-1:0] out_col,
    output logic                                               busy,
    output logic                                               done
);

    localparam int N          = ARRAY_SIZE;
    localparam int IDX_W      = (N > 1) ? $clog2(N) : 1;
    localparam int PROD_W     = 2 * DATA_W;
    localparam int FLUSH_W    = $clog2(2 * N);
    localparam logic [FLUSH_W-1:0] FLUSH_INIT = FLUSH_W'(2 * N - 2);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_FLUSH,
        S_DRAIN
    } state_t;

    state_t               r_state;
    logic [9:0]           r_beat_cnt;
    logic [9:0]           r_beat_max;
    logic [FLUSH_W-1:0]   r_flush_cnt;
    logic                 r_out_valid;
    logic signed [ACC_W-1:0] r_out_data;
    logic [IDX_W-1:0]     r_out_row;
    logic [IDX_W-1:0]     r_out_col;
    logic                 r_done;

    logic                 w_clr;
    logic                 w_inj;
    logic [IDX_W-1:0]     w_nrow;
    logic [IDX_W-1:0]     w_ncol;

    // Skewed edge inputs into the array
    logic signed [DATA_W-1:0] w_row_d [N];
    logic                     w_row_t [N];
    logic signed [DATA_W-1:0] w_col_w [N];
    logic                     w_col_t [N];

    // PE registers
    logic signed [DATA_W-1:0] r_a  [N][N];
    logic signed [DATA_W-1:0] r_b  [N][N];
    logic                     r_at [N][N];
    logic                     r_bt [N][N];
    logic signed [ACC_W-1:0]  r_acc[N][N];

    // PE inputs: left neighbour / top neighbour or array edge
    logic signed [DATA_W-1:0] w_a_in  [N][N];
    logic signed [DATA_W-1:0] w_b_in  [N][N];
    logic                     w_at_in [N][N];
    logic                     w_bt_in [N][N];
    logic signed [PROD_W-1:0] w_prod  [N][N];

    assign w_clr     = (r_state == S_IDLE) && start;
    assign w_inj     = in_valid && (r_state == S_COMPUTE);
    assign in_ready  = (r_state == S_COMPUTE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_row   = r_out_row;
    assign out_col   = r_out_col;
    assign done      = r_done;

    // Row i data sees i skew stages, column j weight sees j stages, so the
    // operands of one beat meet at PE(i,j) i+j cycles after injection.
    for (genvar gi = 0; gi < N; gi++) begin : g_skew
        if (gi == 0) begin : g_direct
            assign w_row_d[gi] = data_in[gi*DATA_W +: DATA_W];
            assign w_row_t[gi] = w_inj;
            assign w_col_w[gi] = weight_in[gi*DATA_W +: DATA_W];
            assign w_col_t[gi] = w_inj;
        end else begin : g_delay
            logic signed [DATA_W-1:0] r_sk_d [gi];
            logic signed [DATA_W-1:0] r_sk_w [gi];
            logic                     r_sk_dt[gi];
            logic                     r_sk_wt[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned s = 0; s < gi; s++) begin
                        r_sk_d[s]  <= '0;
                        r_sk_w[s]  <= '0;
                        r_sk_dt[s] <= 1'b0;
                        r_sk_wt[s] <= 1'b0;
                    end
                end else begin
                    r_sk_d[0]  <= data_in[gi*DATA_W +: DATA_W];
                    r_sk_w[0]  <= weight_in[gi*DATA_W +: DATA_W];
                    r_sk_dt[0] <= w_inj && !w_clr;
                    r_sk_wt[0] <= w_inj && !w_clr;
                    for (int unsigned s = 1; s < gi; s++) begin
                        r_sk_d[s]  <= r_sk_d[s-1];
                        r_sk_w[s]  <= r_sk_w[s-1];
                        r_sk_dt[s] <= r_sk_dt[s-1] && !w_clr;
                        r_sk_wt[s] <= r_sk_wt[s-1] && !w_clr;
                    end
                end
            end

            assign w_row_d[gi] = r_sk_d[gi-1];
            assign w_row_t[gi] = r_sk_dt[gi-1];
            assign w_col_w[gi] = r_sk_w[gi-1];
            assign w_col_t[gi] = r_sk_wt[gi-1];
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_pe_row
        for (genvar gj = 0; gj < N; gj++) begin : g_pe_col
            if (gj == 0) begin : g_a_edge
                assign w_a_in[gi][gj]  = w_row_d[gi];
                assign w_at_in[gi][gj] = w_row_t[gi];
            end else begin : g_a_link
                assign w_a_in[gi][gj]  = r_a[gi][gj-1];
                assign w_at_in[gi][gj] = r_at[gi][gj-1];
            end
            if (gi == 0) begin : g_b_edge
                assign w_b_in[gi][gj]  = w_col_w[gj];
                assign w_bt_in[gi][gj] = w_col_t[gj];
            end else begin : g_b_link
                assign w_b_in[gi][gj]  = r_b[gi-1][gj];
                assign w_bt_in[gi][gj] = r_bt[gi-1][gj];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
                w_prod[i][j] = PROD_W'(r_a[i][j]) * PROD_W'(r_b[i][j]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N; i++) begin
                for (int unsigned j = 0; j < N; j++) begin
                    r_a[i][j]   <= '0;
                    r_b[i][j]   <= '0;
                    r_at[i][j]  <= 1'b0;
                    r_bt[i][j]  <= 1'b0;
                    r_acc[i][j] <= '0;
                end
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                for (int unsigned j = 0; j < N; j++) begin
                    r_a[i][j] <= w_a_in[i][j];
                    r_b[i][j] <= w_b_in[i][j];
                    if (w_clr) begin
                        r_at[i][j]  <= 1'b0;
                        r_bt[i][j]  <= 1'b0;
                        r_acc[i][j] <= '0;
                    end else begin
                        r_at[i][j] <= w_at_in[i][j];
                        r_bt[i][j] <= w_bt_in[i][j];
                        if (r_at[i][j] && r_bt[i][j]) begin
                            r_acc[i][j] <= r_acc[i][j] + ACC_W'(w_prod[i][j]);
                        end
                    end
                end
            end
        end
    end

    // Next drain position in row-major order
    always_comb begin
        w_nrow = r_out_row;
        w_ncol = r_out_col + 1'b1;
        if (r_out_col == LAST_IDX) begin
            w_ncol = '0;
            w_nrow = r_out_row + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_beat_cnt  <= '0;
            r_beat_max  <= '0;
            r_flush_cnt <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_row   <= '0;
            r_out_col   <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_beat_max <= k_len;
                        r_beat_cnt <= '0;
                        if (k_len == 10'd0) begin
                            // Accumulators clear on this same edge, so present zero.
                            r_state     <= S_DRAIN;
                            r_out_valid <= 1'b1;
                            r_out_data  <= '0;
                            r_out_row   <= '0;
                            r_out_col   <= '0;
                        end else begin
                            r_state <= S_COMPUTE;
                        end
                    end
                end
                S_COMPUTE: begin
                    if (in_valid) begin
                        r_beat_cnt <= r_beat_cnt + 10'd1;
                        if (r_beat_cnt == r_beat_max - 10'd1) begin
                            r_state     <= S_FLUSH;
                            r_flush_cnt <= FLUSH_INIT;
                        end
                    end
                end
                S_FLUSH: begin
                    if (r_flush_cnt == '0) begin
                        r_state     <= S_DRAIN;
                        r_out_valid <= 1'b1;
                        r_out_data  <= r_acc[0][0];
                        r_out_row   <= '0;
                        r_out_col   <= '0;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (r_out_row == LAST_IDX && r_out_col == LAST_IDX) begin
                            r_out_valid <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            r_out_row  <= w_nrow;
                            r_out_col  <= w_ncol;
                            r_out_data <= r_acc[w_nrow][w_ncol];
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
